// File: rtl/branch_predict_ctrl_if.sv
// EX-to-predictor resolution bus and the redirect returned to the pipeline.
// EX drives the master side; the predictor answers on the slave side.
interface branch_predict_ctrl_if;
  logic        upd_e;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        mispredict;
  logic [31:0] fix_pc;
  logic        redirect_e;
  logic [31:0] redirect_pc;

  modport master (
    output upd_e,
    output upd_pc,
    output upd_taken,
    output upd_target,
    output mispredict,
    output fix_pc,
    input  redirect_e,
    input  redirect_pc
  );

  modport slave (
    input  upd_e,
    input  upd_pc,
    input  upd_taken,
    input  upd_target,
    input  mispredict,
    input  fix_pc,
    output redirect_e,
    output redirect_pc
  );
endinterface

// File: rtl/branch_predict_ctrl.sv
// Direct-mapped BTB with 2-bit counters, mispredict redirect sequencing
// and wrong-path training suppression.
module branch_predict_ctrl #(
  parameter int ENTRIES    = 64,
  parameter int INDEX_W    = 6,
  parameter int SHADOW_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic [31:0]           if_pc,
  output logic [31:0]           pred_pc,
  output logic                  pred_taken,
  branch_predict_ctrl_if.slave  ex,
  output logic [31:0]           br_cnt,
  output logic [31:0]           miss_cnt
);

  localparam int TAG_W = 32 - INDEX_W - 2;
  localparam int SH_W  =
    (SHADOW_CYC < 2) ? 1 : $clog2(SHADOW_CYC + 1);
  localparam logic [SH_W-1:0] SH_INIT = SH_W'(SHADOW_CYC);
  localparam logic [SH_W-1:0] SH_ONE  = SH_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    SHADOW
  } state_t;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];

  state_t          state_q, state_d;
  logic [SH_W-1:0] shadow_q, shadow_d;
  logic            redir_q, redir_d;
  logic [31:0]     rpc_q, rpc_d;
  logic [31:0]     br_q, miss_q;

  logic [INDEX_W-1:0] lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic               lk_hit;

  logic [INDEX_W-1:0] up_idx;
  logic [TAG_W-1:0]   up_tag;
  logic               up_hit;
  logic               accept;
  logic [1:0]         up_ctr;
  logic               unused_lsb;

  assign unused_lsb = ^{if_pc[1:0], ex.upd_pc[1:0]};

  assign lk_idx = if_pc[INDEX_W+1:2];
  assign lk_tag = if_pc[31:INDEX_W+2];
  assign lk_hit = valid_q[lk_idx] &&
                  (tag_q[lk_idx] == lk_tag);

  assign pred_taken = lk_hit && ctr_q[lk_idx][1];
  assign pred_pc    = pred_taken ? tgt_q[lk_idx]
                                 : if_pc + 32'd4;

  assign up_idx = ex.upd_pc[INDEX_W+1:2];
  assign up_tag = ex.upd_pc[31:INDEX_W+2];
  assign up_hit = valid_q[up_idx] &&
                  (tag_q[up_idx] == up_tag);

  // Wrong-path instructions draining through EX must not train or count.
  assign accept = ex.upd_e && !stall &&
                  (state_q != SHADOW);

  always_comb begin
    up_ctr = ctr_q[up_idx];
    if (ex.upd_taken) begin
      if (up_ctr != 2'd3) up_ctr = up_ctr + 2'd1;
    end else begin
      if (up_ctr != 2'd0) up_ctr = up_ctr - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (accept && !up_hit && ex.upd_taken) begin
      valid_q[up_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      if (up_hit) begin
        ctr_q[up_idx] <= up_ctr;
        if (ex.upd_taken) tgt_q[up_idx] <= ex.upd_target;
      end else if (ex.upd_taken) begin
        tag_q[up_idx] <= up_tag;
        tgt_q[up_idx] <= ex.upd_target;
        ctr_q[up_idx] <= 2'd2;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    redir_d  = redir_q;
    rpc_d    = rpc_q;
    unique case (state_q)
      IDLE: begin
        if (accept && ex.mispredict) begin
          state_d = REDIRECT;
          redir_d = 1'b1;
          rpc_d   = ex.fix_pc;
        end
      end
      REDIRECT: begin
        if (!stall) begin
          redir_d = 1'b0;
          if (SHADOW_CYC == 0) begin
            state_d = IDLE;
          end else begin
            state_d  = SHADOW;
            shadow_d = SH_INIT;
          end
        end
      end
      SHADOW: begin
        if (!stall) begin
          if (shadow_q <= SH_ONE) begin
            shadow_d = '0;
            state_d  = IDLE;
          end else begin
            shadow_d = shadow_q - SH_ONE;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        shadow_d = '0;
        redir_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      redir_q  <= 1'b0;
      rpc_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      redir_q  <= redir_d;
      rpc_q    <= rpc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_q   <= '0;
      miss_q <= '0;
    end else if (accept) begin
      if (br_q != '1) br_q <= br_q + 32'd1;
      if (ex.mispredict && (miss_q != '1))
        miss_q <= miss_q + 32'd1;
    end
  end

  assign ex.redirect_e  = redir_q;
  assign ex.redirect_pc = rpc_q;
  assign br_cnt         = br_q;
  assign miss_cnt       = miss_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: lookup, training, shadow drain,
// stall hold and asynchronous reset.
module tb_branch_predict_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [31:0] if_pc;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  int checks = 0;
  int fails  = 0;
  int exp_br = 0;
  int exp_miss = 0;

  branch_predict_ctrl_if bus ();

  branch_predict_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .if_pc      (if_pc),
    .pred_pc    (pred_pc),
    .pred_taken (pred_taken),
    .ex         (bus.slave),
    .br_cnt     (br_cnt),
    .miss_cnt   (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic [31:0] pc,
                         input logic tk,
                         input logic [31:0] tgt,
                         input logic mis,
                         input logic [31:0] fix);
    bus.upd_e      = 1'b1;
    bus.upd_pc     = pc;
    bus.upd_taken  = tk;
    bus.upd_target = tgt;
    bus.mispredict = mis;
    bus.fix_pc     = fix;
  endtask

  task automatic clr_upd();
    bus.upd_e      = 1'b0;
    bus.upd_pc     = '0;
    bus.upd_taken  = 1'b0;
    bus.upd_target = '0;
    bus.mispredict = 1'b0;
    bus.fix_pc     = '0;
  endtask

  task automatic test_reset();
    if_pc = 32'h0000_1000;
    #1;
    checks++;
    if (pred_pc !== 32'h0000_1004) begin
      fails++;
      $display("FAIL reset_pred_pc got %h exp %h", pred_pc, 32'h1004);
    end
    checks++;
    if (pred_taken !== 1'b0) begin
      fails++;
      $display("FAIL reset_pred_taken got %b exp 0", pred_taken);
    end
    checks++;
    if (bus.redirect_e !== 1'b0) begin
      fails++;
      $display("FAIL reset_redirect got %b exp 0", bus.redirect_e);
    end
    checks++;
    if (br_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      fails++;
      $display("FAIL reset_cnt got %0d/%0d exp 0/0", br_cnt, miss_cnt);
    end
  endtask

  task automatic test_mispredict();
    set_upd(32'h1000, 1'b1, 32'h0F00, 1'b1, 32'h0F00);
    if_pc = 32'h1000;
    #1;
    checks++;
    if (pred_pc !== 32'h1004) begin
      fails++;
      $display("FAIL pre_update_lookup got %h exp %h", pred_pc, 32'h1004);
    end
    tick();
    clr_upd();
    exp_br++;
    exp_miss++;
    checks++;
    if (bus.redirect_e !== 1'b1 || bus.redirect_pc !== 32'h0F00) begin
      fails++;
      $display("FAIL redirect_raise got %b/%h exp 1/%h",
               bus.redirect_e, bus.redirect_pc, 32'h0F00);
    end
    checks++;
    if (br_cnt !== exp_br || miss_cnt !== exp_miss) begin
      fails++;
      $display("FAIL mis_cnt got %0d/%0d exp %0d/%0d",
               br_cnt, miss_cnt, exp_br, exp_miss);
    end
    checks++;
    if (pred_pc !== 32'h0F00 || pred_taken !== 1'b1) begin
      fails++;
      $display("FAIL alloc_lookup got %h/%b exp %h/1",
               pred_pc, pred_taken, 32'h0F00);
    end
    tick();
    checks++;
    if (bus.redirect_e !== 1'b0) begin
      fails++;
      $display("FAIL redirect_pulse got %b exp 0", bus.redirect_e);
    end
  endtask

  task automatic test_shadow();
    set_upd(32'h1000, 1'b0, 32'h0, 1'b1, 32'h1004);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (br_cnt !== exp_br || bus.redirect_e !== 1'b0) begin
        fails++;
        $display("FAIL shadow_ignore%0d got %0d/%b exp %0d/0",
                 i, br_cnt, bus.redirect_e, exp_br);
      end
    end
    set_upd(32'h3000, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    clr_upd();
    exp_br++;
    checks++;
    if (br_cnt !== exp_br || miss_cnt !== exp_miss) begin
      fails++;
      $display("FAIL shadow_exit got %0d/%0d exp %0d/%0d",
               br_cnt, miss_cnt, exp_br, exp_miss);
    end
    if_pc = 32'h1000;
    #1;
    checks++;
    if (pred_pc !== 32'h0F00) begin
      fails++;
      $display("FAIL shadow_no_train got %h exp %h", pred_pc, 32'h0F00);
    end
    if_pc = 32'h3000;
    #1;
    checks++;
    if (pred_pc !== 32'h3004 || pred_taken !== 1'b0) begin
      fails++;
      $display("FAIL nt_no_alloc got %h/%b exp %h/0",
               pred_pc, pred_taken, 32'h3004);
    end
  endtask

  task automatic test_hysteresis();
    if_pc = 32'h1000;
    set_upd(32'h1000, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    exp_br += 2;
    checks++;
    if (pred_pc !== 32'h1004 || pred_taken !== 1'b0) begin
      fails++;
      $display("FAIL hyst_nt2 got %h/%b exp %h/0",
               pred_pc, pred_taken, 32'h1004);
    end
    set_upd(32'h1000, 1'b1, 32'h0F00, 1'b0, 32'h0);
    tick();
    exp_br++;
    checks++;
    if (pred_pc !== 32'h1004) begin
      fails++;
      $display("FAIL hyst_t1 got %h exp %h", pred_pc, 32'h1004);
    end
    tick();
    clr_upd();
    exp_br++;
    checks++;
    if (pred_pc !== 32'h0F00 || pred_taken !== 1'b1) begin
      fails++;
      $display("FAIL hyst_t2 got %h/%b exp %h/1",
               pred_pc, pred_taken, 32'h0F00);
    end
    checks++;
    if (br_cnt !== exp_br || miss_cnt !== exp_miss) begin
      fails++;
      $display("FAIL hyst_cnt got %0d/%0d exp %0d/%0d",
               br_cnt, miss_cnt, exp_br, exp_miss);
    end
  endtask

  task automatic test_alias();
    if_pc = 32'h1100;
    #1;
    checks++;
    if (pred_pc !== 32'h1104) begin
      fails++;
      $display("FAIL alias_miss got %h exp %h", pred_pc, 32'h1104);
    end
    set_upd(32'h1100, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    exp_br++;
    if_pc = 32'h1000;
    #1;
    checks++;
    if (pred_pc !== 32'h0F00) begin
      fails++;
      $display("FAIL alias_nt_keep got %h exp %h", pred_pc, 32'h0F00);
    end
    set_upd(32'h1100, 1'b1, 32'h2000, 1'b0, 32'h0);
    tick();
    clr_upd();
    exp_br++;
    checks++;
    if (pred_pc !== 32'h1004) begin
      fails++;
      $display("FAIL alias_evict got %h exp %h", pred_pc, 32'h1004);
    end
    if_pc = 32'h1100;
    #1;
    checks++;
    if (pred_pc !== 32'h2000 || pred_taken !== 1'b1) begin
      fails++;
      $display("FAIL alias_new got %h/%b exp %h/1",
               pred_pc, pred_taken, 32'h2000);
    end
  endtask

  task automatic test_wrap();
    if_pc = 32'hFFFF_FFFC;
    #1;
    checks++;
    if (pred_pc !== 32'h0 || pred_taken !== 1'b0) begin
      fails++;
      $display("FAIL wrap got %h/%b exp 0/0", pred_pc, pred_taken);
    end
  endtask

  task automatic test_stall();
    if_pc = 32'h1100;
    stall = 1'b1;
    set_upd(32'h1100, 1'b0, 32'h0, 1'b1, 32'h1104);
    tick();
    checks++;
    if (br_cnt !== exp_br || miss_cnt !== exp_miss ||
        bus.redirect_e !== 1'b0) begin
      fails++;
      $display("FAIL stall_ignore got %0d/%0d/%b exp %0d/%0d/0",
               br_cnt, miss_cnt, bus.redirect_e, exp_br, exp_miss);
    end
    checks++;
    if (pred_pc !== 32'h2000) begin
      fails++;
      $display("FAIL stall_no_train got %h exp %h", pred_pc, 32'h2000);
    end
    stall = 1'b0;
    tick();
    clr_upd();
    stall = 1'b1;
    exp_br++;
    exp_miss++;
    checks++;
    if (br_cnt !== exp_br || miss_cnt !== exp_miss ||
        pred_pc !== 32'h1104) begin
      fails++;
      $display("FAIL stall_accept got %0d/%0d/%h exp %0d/%0d/%h",
               br_cnt, miss_cnt, pred_pc, exp_br, exp_miss, 32'h1104);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.redirect_e !== 1'b1 || bus.redirect_pc !== 32'h1104) begin
        fails++;
        $display("FAIL redirect_hold%0d got %b/%h exp 1/%h",
                 i, bus.redirect_e, bus.redirect_pc, 32'h1104);
      end
      if (i < 2) tick();
    end
    stall = 1'b0;
    tick();
    checks++;
    if (bus.redirect_e !== 1'b0) begin
      fails++;
      $display("FAIL redirect_release got %b exp 0", bus.redirect_e);
    end
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    set_upd(32'h1100, 1'b1, 32'h2000, 1'b1, 32'h2000);
    tick();
    clr_upd();
    stall = 1'b1;
    tick();
    checks++;
    if (bus.redirect_e !== 1'b1 || bus.redirect_pc !== 32'h2000) begin
      fails++;
      $display("FAIL pre_rst_hold got %b/%h exp 1/%h",
               bus.redirect_e, bus.redirect_pc, 32'h2000);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.redirect_e !== 1'b0 || bus.redirect_pc !== 32'h0) begin
      fails++;
      $display("FAIL async_rst got %b/%h exp 0/0",
               bus.redirect_e, bus.redirect_pc);
    end
    checks++;
    if (br_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      fails++;
      $display("FAIL rst_cnt got %0d/%0d exp 0/0", br_cnt, miss_cnt);
    end
    if_pc = 32'h1100;
    #1;
    checks++;
    if (pred_pc !== 32'h1104 || pred_taken !== 1'b0) begin
      fails++;
      $display("FAIL rst_valid got %h/%b exp %h/0",
               pred_pc, pred_taken, 32'h1104);
    end
    tick();
    stall = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    if_pc = '0;
    clr_upd();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_mispredict();
    test_shadow();
    test_hysteresis();
    test_alias();
    test_wrap();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
